// File: rtl/rgb_luma_pipe_if.sv
// Pixel-in / luma-out stream bundle for rgb_luma_pipe.
// Upstream side: valid_i/ready_o with r_i, g_i, b_i and last_i.
// Downstream side: valid_o/ready_i with luma_o and last_o.
interface rgb_luma_pipe_if #(
  parameter int Width = 8
);
  logic             valid_i;
  logic             ready_o;
  logic [Width-1:0] r_i;
  logic [Width-1:0] g_i;
  logic [Width-1:0] b_i;
  logic             last_i;
  logic             valid_o;
  logic             ready_i;
  logic [Width-1:0] luma_o;
  logic             last_o;

  // Stream source/sink: drives pixels in and ready downstream.
  modport master (
    output valid_i, r_i, g_i, b_i, last_i, ready_i,
    input  ready_o, valid_o, luma_o, last_o
  );

  // The converter itself.
  modport slave (
    input  valid_i, r_i, g_i, b_i, last_i, ready_i,
    output ready_o, valid_o, luma_o, last_o
  );
endinterface

// File: rtl/rgb_luma_pipe.sv
// Fixed-point RGB to luma: Y = (Wr*R + Wg*G + Wb*B + 2^(Frac-1)) >> Frac, round-half-up.
// Latency 2 cycles, 1 pixel/cycle; end-of-line marker travels in lockstep with its pixel.
// Backpressure stalls the whole pipe: en = ~v2_r | ready_i, ready_o = en (only comb path).
// Ports: clk_i, reset_ni (async active-low), bus (slave modport of rgb_luma_pipe_if).
module rgb_luma_pipe #(
  parameter int Width   = 8,
  parameter int Frac    = 8,
  parameter int WeightR = 77,
  parameter int WeightG = 150,
  parameter int WeightB = 29
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  rgb_luma_pipe_if.slave  bus
);

  localparam int PW = Width + Frac;      // product width
  localparam int SW = Width + Frac + 2;  // sum width, headroom for three terms

  localparam logic [PW-1:0] WR  = PW'(WeightR);
  localparam logic [PW-1:0] WG  = PW'(WeightG);
  localparam logic [PW-1:0] WB  = PW'(WeightB);
  localparam logic [SW-1:0] RND = SW'(2 ** (Frac - 1));

  // Weights summing to at most 1.0 is what guarantees the result fits in
  // Width bits without any clipping stage.
  if (Frac < 1 || (WeightR + WeightG + WeightB) > (2 ** Frac)) begin : g_illegal_weights
    $error("rgb_luma_pipe: weights must sum to <= 2^Frac and Frac must be >= 1");
  end

  logic             en;
  logic             v1_r, v2_r;
  logic             l1_r, l2_r;
  logic [PW-1:0]    pr_r, pg_r, pb_r;
  logic [SW-1:0]    sum;
  logic [Width-1:0] luma_r;

  assign en  = ~v2_r | bus.ready_i;
  assign sum = SW'(pr_r) + SW'(pg_r) + SW'(pb_r) + RND;

  // Stage 1: per-channel products. Data loads on en whether or not the
  // pixel is valid; the valid bit alone qualifies it downstream.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      v1_r <= 1'b0;
      l1_r <= 1'b0;
      pr_r <= '0;
      pg_r <= '0;
      pb_r <= '0;
    end else if (en) begin
      v1_r <= bus.valid_i;
      l1_r <= bus.last_i;
      pr_r <= WR * PW'(bus.r_i);
      pg_r <= WG * PW'(bus.g_i);
      pb_r <= WB * PW'(bus.b_i);
    end
  end

  // Stage 2: rounded sum, shifted back to integer luma. Holding on !en
  // keeps luma_o/last_o stable while the output is stalled.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      v2_r   <= 1'b0;
      l2_r   <= 1'b0;
      luma_r <= '0;
    end else if (en) begin
      v2_r   <= v1_r;
      l2_r   <= l1_r;
      luma_r <= Width'(sum >> Frac);
    end
  end

  assign bus.ready_o = en;
  assign bus.valid_o = v2_r;
  assign bus.luma_o  = luma_r;
  assign bus.last_o  = l2_r;

endmodule

// File: tb/tb_rgb_luma_pipe.sv
module tb_rgb_luma_pipe;

  localparam int W  = 8;
  localparam int F  = 8;
  localparam int WR = 77;
  localparam int WG = 150;
  localparam int WB = 29;

  logic clk_i    = 1'b0;
  logic reset_ni = 1'b0;

  always #5 clk_i = ~clk_i;

  rgb_luma_pipe_if #(.Width(W)) bus ();

  rgb_luma_pipe #(
    .Width(W), .Frac(F), .WeightR(WR), .WeightG(WG), .WeightB(WB)
  ) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  typedef struct { int r; int g; int b; bit last; } pix_t;
  typedef struct { int luma; bit last; int key; } exp_t;

  pix_t src_q[$];
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int stalls = 0;
  int out_cnt = 0;
  int in_cnt  = 0;
  int last_hits = 0;
  int last_at   = -1;
  bit prev_hold = 1'b0;
  logic [W-1:0] prev_luma;
  logic         prev_last;
  exp_t e;

  // Reference: integer arithmetic straight from the luma formula.
  function automatic int ref_luma(input int r, input int g, input int b);
    return (WR * r + WG * g + WB * b + (1 << (F - 1))) / (1 << F);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard / monitor. The latency key is cycle minus cycles-with-en=0,
  // so an item must emerge exactly 2 non-stalled cycles after acceptance.
  always @(negedge clk_i) begin
    if (!reset_ni) begin
      sb_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("stall_valid", bus.valid_o, 1);
        chk("stall_luma", bus.luma_o, prev_luma);
        chk("stall_last", bus.last_o, prev_last);
      end
      chk("ready_rule", bus.ready_o, (!bus.valid_o || bus.ready_i));
      if (bus.valid_o && bus.ready_i) begin
        if (sb_q.size() == 0) begin
          chk("spurious_output", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("luma", bus.luma_o, e.luma);
          chk("last", bus.last_o, e.last);
          chk("latency", cyc - stalls, e.key + 2);
        end
        if (bus.last_o) begin
          last_hits++;
          last_at = out_cnt;
        end
        out_cnt++;
      end
      if (bus.valid_i && bus.ready_o) begin
        e.luma = ref_luma(int'(bus.r_i), int'(bus.g_i), int'(bus.b_i));
        e.last = bus.last_i;
        e.key  = cyc - stalls;
        sb_q.push_back(e);
        in_cnt++;
      end
      if (!bus.ready_o) stalls++;
      prev_hold = bus.valid_o && !bus.ready_i;
      prev_luma = bus.luma_o;
      prev_last = bus.last_o;
    end
    cyc++;
  end

  // Sends everything in src_q. Entered and left at posedge+1.
  // rmode: 0 ready_i=1, 1 random ready_i, 2 four-cycle stall at cycles 3..6.
  task automatic drive(input int rmode, input int vpct, input int rpct);
    int c = 0;
    pix_t p;
    while (src_q.size() > 0) begin
      p = src_q[0];
      bus.valid_i = ($urandom_range(99) < vpct);
      bus.r_i     = p.r[W-1:0];
      bus.g_i     = p.g[W-1:0];
      bus.b_i     = p.b[W-1:0];
      bus.last_i  = p.last;
      case (rmode)
        0:       bus.ready_i = 1'b1;
        1:       bus.ready_i = ($urandom_range(99) < rpct);
        default: bus.ready_i = !(c >= 3 && c < 7);
      endcase
      @(negedge clk_i);
      if (rmode == 2 && c >= 3 && c < 7) chk("bp_ready_o_low", bus.ready_o, 0);
      if (bus.valid_i && bus.ready_o) void'(src_q.pop_front());
      @(posedge clk_i);
      #1;
      c++;
      if (c > 60000) begin
        chk("drive_timeout", 1, 0);
        src_q.delete();
      end
    end
    bus.valid_i = 1'b0;
    bus.last_i  = 1'b0;
    bus.ready_i = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk("drain_empty", sb_q.size(), 0);
  endtask

  task automatic push_pix(input int r, input int g, input int b, input bit last);
    pix_t p;
    p.r = r; p.g = g; p.b = b; p.last = last;
    src_q.push_back(p);
  endtask

  int base;
  int base_in;

  initial begin
    bus.valid_i = 1'b1;
    bus.ready_i = 1'b1;
    bus.r_i = 8'd200; bus.g_i = 8'd100; bus.b_i = 8'd50;
    bus.last_i = 1'b1;

    // Reset held with valid_i=1: outputs stay quiet.
    repeat (3) begin
      @(negedge clk_i);
      chk("reset_valid_o", bus.valid_o, 0);
      chk("reset_luma_o", bus.luma_o, 0);
      chk("reset_last_o", bus.last_o, 0);
    end
    @(posedge clk_i);
    #1;
    reset_ni    = 1'b1;
    bus.valid_i = 1'b0;
    bus.last_i  = 1'b0;

    // Arithmetic vectors, back to back.
    push_pix(255, 255, 255, 0);
    push_pix(0, 0, 0, 0);
    push_pix(255, 0, 0, 0);
    push_pix(0, 255, 0, 0);
    push_pix(0, 0, 255, 0);
    push_pix(100, 150, 200, 1);
    drive(0, 100, 100);
    drain();

    // Backpressure: stall 4 cycles with the 2nd pixel on the output.
    base = out_cnt;
    for (int i = 0; i < 6; i++) push_pix($urandom_range(255), $urandom_range(255), $urandom_range(255), i[0]);
    drive(2, 100, 100);
    drain();
    chk("bp_all_out", out_cnt - base, 6);

    // Last marker on the 4th of 8 pixels, random valid/ready.
    base = out_cnt;
    last_hits = 0;
    for (int i = 0; i < 8; i++) push_pix($urandom_range(255), $urandom_range(255), $urandom_range(255), (i == 3));
    drive(1, 60, 50);
    drain();
    chk("last_hits", last_hits, 1);
    chk("last_position", last_at - base, 3);

    // Mid-stream reset with two pixels in flight.
    push_pix(10, 20, 30, 0);
    push_pix(40, 50, 60, 1);
    drive(0, 100, 100);
    #2;
    chk("pre_reset_valid_o", bus.valid_o, 1);
    reset_ni = 1'b0;
    #1;
    chk("async_reset_valid_o", bus.valid_o, 0);
    chk("async_reset_luma_o", bus.luma_o, 0);
    repeat (2) @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    base = out_cnt;
    repeat (8) @(posedge clk_i);
    #1;
    chk("no_stale_after_reset", out_cnt - base, 0);

    // Random soak.
    base    = out_cnt;
    base_in = in_cnt;
    for (int i = 0; i < 10000; i++)
      push_pix($urandom_range(255), $urandom_range(255), $urandom_range(255), ($urandom_range(7) == 0));
    drive(1, 75, 70);
    drain();
    chk("soak_in_count", in_cnt - base_in, 10000);
    chk("soak_out_count", out_cnt - base, 10000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
